// File: rtl/riscv_pkg.sv
// Shared fetch types and opcode constants.
// FAULT state exists only when IFETCH_OPCODE_CHECK_EN is defined.
package riscv_pkg;

  localparam int XLEN_DEF = 64;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

`ifdef IFETCH_OPCODE_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_FAULT
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } fetch_state_t;
`endif

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_INC,
    PC_JMP
  } pc_sel_t;

  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/ifetch_pc.sv
// Next-PC select: hold, sequential +4, or redirect target.
// Redirect targets are forced to word alignment.
module ifetch_pc
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_base,
  input  logic [XLEN-1:0] i_target,
  input  pc_sel_t         i_sel,
  output logic [XLEN-1:0] o_next
);

  always_comb begin
    o_next = i_pc;
    unique case (i_sel)
      PC_INC:  o_next = i_base + XLEN'(4);
      PC_JMP:  o_next = i_target & ~XLEN'(3);
      default: o_next = i_pc;
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// Sequential fetch unit: imem req/ack, decode valid/ready, branch redirect.
// Define IFETCH_OPCODE_CHECK_EN to trap unknown opcodes in a FAULT state.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_out,
  output logic [6:0]      opcode_out,
  output logic [XLEN-1:0] pc_out,
  input  logic            branch_in,
  input  logic            zero_in,
  input  logic [XLEN-1:0] branch_target,
  output logic            illegal_out
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic [XLEN-1:0] w_pc_next;
  logic            w_redir;
  logic            w_take;
  pc_sel_t         w_sel;

`ifdef IFETCH_OPCODE_CHECK_EN
  logic r_illegal;
  logic w_bad;
  assign w_bad       = ~op_legal(imem_rdata[6:0]);
  assign illegal_out = r_illegal;
  // A faulted unit is frozen, so redirects are ignored there.
  assign w_redir = branch_in & zero_in & (r_state != S_FAULT);
`else
  assign illegal_out = 1'b0;
  assign w_redir     = branch_in & zero_in;
`endif

  assign w_take = (r_state == S_REQ) & imem_ack
                & ~r_kill & ~w_redir;

  always_comb begin
    w_sel = PC_HOLD;
    if (w_redir)     w_sel = PC_JMP;
    else if (w_take) w_sel = PC_INC;
  end

  ifetch_pc #(.XLEN(XLEN)) u_pc (
    .i_pc     (r_pc),
    .i_base   (imem_addr),
    .i_target (branch_target),
    .i_sel    (w_sel),
    .o_next   (w_pc_next)
  );

  assign opcode_out = inst_out[6:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_kill     <= 1'b0;
      imem_req   <= 1'b0;
      imem_addr  <= RESET_PC;
      inst_valid <= 1'b0;
      inst_out   <= '0;
      pc_out     <= '0;
`ifdef IFETCH_OPCODE_CHECK_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      r_pc <= w_pc_next;
      unique case (r_state)
        S_IDLE: begin
          r_state   <= S_REQ;
          imem_req  <= 1'b1;
          imem_addr <= w_pc_next;
        end
        S_REQ: begin
          if (imem_ack) begin
            r_kill <= 1'b0;
            if (w_take) begin
              inst_out   <= imem_rdata;
              pc_out     <= imem_addr;
              inst_valid <= 1'b1;
              imem_req   <= 1'b0;
`ifdef IFETCH_OPCODE_CHECK_EN
              if (w_bad) begin
                r_illegal <= 1'b1;
                r_state   <= S_FAULT;
              end else begin
                r_state <= S_HOLD;
              end
`else
              r_state <= S_HOLD;
`endif
            end else begin
              // Dropped response: reissue at the current pc.
              imem_addr <= w_pc_next;
            end
          end else if (w_redir) begin
            r_kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (inst_ready || w_redir) begin
            inst_valid <= 1'b0;
            imem_req   <= 1'b1;
            imem_addr  <= w_pc_next;
            r_state    <= S_REQ;
          end
        end
`ifdef IFETCH_OPCODE_CHECK_EN
        S_FAULT: r_state <= S_FAULT;
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch; memory model acks at negedge.
// Opcode trap checks follow IFETCH_OPCODE_CHECK_EN.
module tb_instr_fetch;

  localparam int XLEN = 64;

  typedef struct {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack = 1'b0;
  logic [31:0]     imem_rdata = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst_out;
  logic [6:0]      opcode_out;
  logic [XLEN-1:0] pc_out;
  logic            branch_in = 1'b0;
  logic            zero_in = 1'b0;
  logic [XLEN-1:0] branch_target = '0;
  logic            illegal_out;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t q[$];

  logic            stall_en = 1'b0;
  logic [XLEN-1:0] stall_addr = '0;
  logic            ovr_en = 1'b0;
  logic [XLEN-1:0] ovr_addr = '0;
  logic [31:0]     ovr_data = '0;

  instr_fetch #(.XLEN(XLEN), .RESET_PC('0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .opcode_out    (opcode_out),
    .pc_out        (pc_out),
    .branch_in     (branch_in),
    .zero_in       (zero_in),
    .branch_target (branch_target),
    .illegal_out   (illegal_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return {a[26:2], 7'h33};
  endfunction

  always @(negedge clk) begin
    if (imem_req && !(stall_en && imem_addr == stall_addr)) begin
      imem_ack = 1'b1;
      imem_rdata = (ovr_en && imem_addr == ovr_addr) ?
                   ovr_data : mem_word(imem_addr);
    end else begin
      imem_ack = 1'b0;
      imem_rdata = '0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    branch_in = 1'b0;
    zero_in = 1'b0;
    inst_ready = 1'b0;
    stall_en = 1'b0;
    ovr_en = 1'b0;
    q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== '0 || inst_valid !== 1'b0 ||
        inst_out !== '0 || opcode_out !== '0 || pc_out !== '0 ||
        illegal_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_vals: req=%b addr=%h v=%b inst=%h op=%h pc=%h ill=%b want all 0",
               imem_req, imem_addr, inst_valid, inst_out, opcode_out,
               pc_out, illegal_out);
    end
    stall_en = 1'b1;
    stall_addr = '0;
    rst = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_req: got %b want 0", imem_req);
    end
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== '0) begin
      n_bad++;
      $display("FAIL first_req: req=%b addr=%h want 1/0", imem_req, imem_addr);
    end
    stall_en = 1'b0;
  endtask

  task automatic test_seq_fetch();
    logic [XLEN-1:0] aq[$];
    logic prev_v;
    int got;
    exp_t e;
    apply_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      aq.push_back(XLEN'(4 * i));
      q.push_back('{mem_word(XLEN'(4 * i)), XLEN'(4 * i)});
    end
    prev_v = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      tick();
      if (imem_req && imem_ack && aq.size() > 0) begin
        n_cmp++;
        if (imem_addr !== aq[0]) begin
          n_bad++;
          $display("FAIL seq_addr: got %h want %h", imem_addr, aq[0]);
        end
        void'(aq.pop_front());
      end
      if (inst_valid) begin
        n_cmp++;
        if (prev_v !== 1'b0) begin
          n_bad++;
          $display("FAIL seq_alternate: valid high two cycles, want pulse");
        end
        e = q.pop_front();
        n_cmp++;
        if (inst_out !== e.inst || pc_out !== e.pc ||
            opcode_out !== e.inst[6:0]) begin
          n_bad++;
          $display("FAIL seq_data: inst=%h pc=%h op=%h want %h %h %h",
                   inst_out, pc_out, opcode_out, e.inst, e.pc, e.inst[6:0]);
        end
        got++;
      end
      prev_v = inst_valid;
    end
    n_cmp++;
    if (got != 3) begin
      n_bad++;
      $display("FAIL seq_timeout: got %0d want 3", got);
    end
  endtask

  task automatic test_hold_stall();
    apply_reset();
    ovr_en = 1'b1;
    ovr_addr = '0;
    ovr_data = 32'h0000_0033;
    for (int c = 0; c < 10 && !inst_valid; c++) tick();
    n_cmp++;
    if (!inst_valid) begin
      n_bad++;
      $display("FAIL hold_timeout: valid=%b want 1", inst_valid);
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (inst_valid !== 1'b1 || inst_out !== 32'h33 ||
          pc_out !== '0 || imem_req !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable: v=%b inst=%h pc=%h req=%b want 1 33 0 0",
                 inst_valid, inst_out, pc_out, imem_req);
      end
      tick();
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h4 || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_next: req=%b addr=%h v=%b want 1 4 0",
               imem_req, imem_addr, inst_valid);
    end
  endtask

  task automatic test_redirect_hold();
    exp_t e;
    apply_reset();
    for (int c = 0; c < 10 && !inst_valid; c++) tick();
    q.push_back('{mem_word(64'h100), 64'h100});
    branch_in = 1'b1;
    zero_in = 1'b1;
    branch_target = 64'h103;
    tick();
    branch_in = 1'b0;
    zero_in = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
      n_bad++;
      $display("FAIL redir_hold: v=%b req=%b addr=%h want 0 1 100",
               inst_valid, imem_req, imem_addr);
    end
    tick();
    e = q.pop_front();
    n_cmp++;
    if (inst_valid !== 1'b1 || pc_out !== e.pc || inst_out !== e.inst) begin
      n_bad++;
      $display("FAIL redir_hold_data: v=%b pc=%h inst=%h want 1 %h %h",
               inst_valid, pc_out, inst_out, e.pc, e.inst);
    end
  endtask

  task automatic test_redirect_req();
    logic redir;
    logic seen_new;
    int rc;
    exp_t e;
    apply_reset();
    inst_ready = 1'b1;
    stall_en = 1'b1;
    stall_addr = 64'h8;
    q.push_back('{mem_word(64'h0), 64'h0});
    q.push_back('{mem_word(64'h4), 64'h4});
    q.push_back('{mem_word(64'h40), 64'h40});
    redir = 1'b0;
    seen_new = 1'b0;
    rc = 0;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      tick();
      branch_in = 1'b0;
      zero_in = 1'b0;
      if (inst_valid) begin
        e = q.pop_front();
        n_cmp++;
        if (pc_out !== e.pc || inst_out !== e.inst) begin
          n_bad++;
          $display("FAIL redir_req_data: pc=%h inst=%h want %h %h",
                   pc_out, inst_out, e.pc, e.inst);
        end
      end
      if (redir && c == rc + 1) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin
          n_bad++;
          $display("FAIL redir_req_hold: req=%b addr=%h want 1 8",
                   imem_req, imem_addr);
        end
      end
      if (redir && c == rc + 3) stall_en = 1'b0;
      if (redir && !seen_new && imem_req && imem_addr != 64'h8) begin
        seen_new = 1'b1;
        n_cmp++;
        if (imem_addr !== 64'h40) begin
          n_bad++;
          $display("FAIL redir_req_addr: got %h want 40", imem_addr);
        end
      end
      if (!redir && imem_req && imem_addr == 64'h8) begin
        redir = 1'b1;
        rc = c;
        branch_in = 1'b1;
        zero_in = 1'b1;
        branch_target = 64'h40;
      end
    end
    n_cmp++;
    if (q.size() != 0 || !seen_new) begin
      n_bad++;
      $display("FAIL redir_req_timeout: left=%0d seen=%b want 0 1",
               q.size(), seen_new);
    end
  endtask

  task automatic test_wrap();
    logic done;
    exp_t e;
    apply_reset();
    inst_ready = 1'b1;
    q.push_back('{mem_word(64'h0), 64'h0});
    q.push_back('{mem_word(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC});
    q.push_back('{mem_word(64'h0), 64'h0});
    done = 1'b0;
    for (int c = 0; c < 30 && q.size() > 0; c++) begin
      tick();
      branch_in = 1'b0;
      zero_in = 1'b0;
      if (inst_valid) begin
        e = q.pop_front();
        n_cmp++;
        if (pc_out !== e.pc || inst_out !== e.inst) begin
          n_bad++;
          $display("FAIL wrap_data: pc=%h inst=%h want %h %h",
                   pc_out, inst_out, e.pc, e.inst);
        end
        if (!done) begin
          done = 1'b1;
          branch_in = 1'b1;
          zero_in = 1'b1;
          branch_target = '1;
        end
      end
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL wrap_timeout: left=%0d want 0", q.size());
    end
  endtask

  task automatic test_opcode();
    apply_reset();
    inst_ready = 1'b1;
    ovr_en = 1'b1;
    ovr_addr = '0;
    ovr_data = 32'h0000_007F;
    for (int c = 0; c < 10 && !inst_valid; c++) tick();
    n_cmp++;
    if (inst_valid !== 1'b1 || inst_out !== 32'h7F || pc_out !== '0) begin
      n_bad++;
      $display("FAIL op_capture: v=%b inst=%h pc=%h want 1 7f 0",
               inst_valid, inst_out, pc_out);
    end
`ifdef IFETCH_OPCODE_CHECK_EN
    n_cmp++;
    if (illegal_out !== 1'b1) begin
      n_bad++;
      $display("FAIL op_illegal: got %b want 1", illegal_out);
    end
    for (int c = 0; c < 8; c++) begin
      branch_in = c[0];
      zero_in = 1'b1;
      branch_target = 64'h200;
      tick();
      n_cmp++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 ||
          inst_out !== 32'h7F || illegal_out !== 1'b1) begin
        n_bad++;
        $display("FAIL op_fault_hold: req=%b v=%b inst=%h ill=%b want 0 1 7f 1",
                 imem_req, inst_valid, inst_out, illegal_out);
      end
    end
    branch_in = 1'b0;
    zero_in = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (illegal_out !== 1'b0 || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL op_rst_exit: ill=%b v=%b want 0 0", illegal_out, inst_valid);
    end
    rst = 1'b0;
`else
    n_cmp++;
    if (illegal_out !== 1'b0) begin
      n_bad++;
      $display("FAIL op_no_trap: got %b want 0", illegal_out);
    end
    tick();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h4 || illegal_out !== 1'b0) begin
      n_bad++;
      $display("FAIL op_continue: req=%b addr=%h ill=%b want 1 4 0",
               imem_req, imem_addr, illegal_out);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_hold_stall();
    test_redirect_hold();
    test_redirect_req();
    test_wrap();
    test_opcode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Sequential instruction fetch unit; produces the instruction words whose opcode field drives the main control decoder.
- Holds the PC and runs a request/acknowledge handshake to instruction memory.
- Presents each fetched instruction to decode through a valid/ready handshake.
- Redirects the PC when the decoder's branch signal and the ALU zero flag are both high.

## Interface
- XLEN, 64, PC and address width.
- RESET_PC, 0, first fetch address after reset; low two bits must be 0.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  request to instruction memory; held until imem_ack.
- imem_addr  out  XLEN  word address; stable while imem_req is high.
- imem_ack  in  1  memory completes the transaction this cycle.
- imem_rdata  in  32  instruction word; valid when imem_ack is high.
- inst_valid  out  1  inst_out/pc_out hold a live instruction.
- inst_ready  in  1  decode accepts the instruction this cycle.
- inst_out  out  32  fetched instruction.
- opcode_out  out  7  inst_out[6:0], fed to the control decoder.
- pc_out  out  XLEN  address inst_out was fetched from.
- branch_in  in  1  branch control signal from the decoder.
- zero_in  in  1  ALU zero flag.
- branch_target  in  XLEN  target PC; bits [1:0] are forced to 0.
- illegal_out  out  1  illegal opcode flag (see Configuration).

## Operation
- States:
  - IDLE: one cycle after reset.
  - REQ: imem_req=1, waiting for imem_ack.
  - HOLD: inst_valid=1, waiting for inst_ready.
  - FAULT: only with the macro enabled.
- Internal registers: pc (next fetch address) and kill (discard the pending response).
- State transitions:
  - IDLE -> REQ: imem_addr<=pc.
  - REQ with imem_ack and kill=0: inst_out<=imem_rdata, pc_out<=imem_addr, inst_valid<=1, pc<=imem_addr+4, imem_req<=0, go to HOLD.
  - REQ with imem_ack and kill=1: discard the data, clear kill, stay in REQ with imem_addr<=pc, a new request.
  - HOLD with inst_valid&inst_ready: inst_valid<=0, go to REQ with imem_addr<=pc.
- Redirect condition: branch_in&zero_in, sampled every cycle. It overrides the pc update, and pc<=branch_target&~3.
  - IDLE: the pc update only.
  - HOLD without ready: the held instruction is dropped (inst_valid<=0) and the FSM goes to REQ at the target.
  - HOLD with ready: the instruction counts as consumed and the FSM goes to REQ at the target.
  - REQ without ack: kill<=1. imem_addr does not change until the ack.
  - REQ with ack: the data is discarded and the next request uses the target.
- PC arithmetic: unsigned modulo 2^XLEN; 2^XLEN-4 wraps to 0.
- opcode_out is combinational from inst_out.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst_out=0, opcode_out=0, pc_out=0, illegal_out=0, pc=RESET_PC, kill=0, state=IDLE.
- All outputs are registered except opcode_out.
- First imem_req is the first cycle after the first clk edge following rst deassertion.
- Memory may ack in the same cycle imem_req first rises. inst_valid then rises on the next edge.
- Peak throughput: one instruction per 2 cycles.
- Reset mid-transaction: all state clears immediately. Any late imem_ack is ignored because imem_req=0.

## Configuration
- Macro: IFETCH_OPCODE_CHECK_EN.
- With the macro defined:
  - On an ack (kill=0) whose opcode is not 0110011, 0000011, 0100011 or 1100011, capture the instruction as normal, set illegal_out=1 and go to FAULT.
  - FAULT keeps inst_valid=1 and holds the instruction.
  - FAULT ignores inst_ready and redirects and issues no requests.
  - Only rst exits FAULT.
- Without the macro: illegal_out is tied to 0, FAULT does not exist, and every opcode is passed to decode.

## Structure
- Shared package riscv_pkg:
  - opcode constants OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH;
  - default XLEN;
  - the fetch state enum.
- Sub-module ifetch_pc: the next-PC mux (hold / +4 / redirect target with bits [1:0] cleared), instantiated once.

## Test plan
- Reset release, RESET_PC=0, memory acks immediately, inst_ready=1, three fetches -> imem_addr sequence 0, 4, 8; inst_valid pulses on alternate cycles; pc_out 0, 4, 8.
- Fetch returns 32'h00000033 and inst_ready is held low for 5 cycles -> inst_out and pc_out stable, inst_valid=1, imem_req=0 throughout; the next request goes to addr+4 after ready.
- Branch_in=zero_in=1 with target 0x103 while in HOLD without ready -> instruction dropped; next imem_addr=0x100.
- Redirect to 0x40 while a request to 0x8 is outstanding, ack 3 cycles later -> that data is never valid; the next request is 0x40.
- pc=2^64-4 -> the following fetch address is 0.
- Macro on, fetch 32'h0000007F -> illegal_out=1, no further imem_req until rst; macro off -> inst_valid normal, illegal_out=0.
